// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared types and limits for the bit-serial adder controller.
//   bsa_state_t : controller FSM states (IDLE -> RUN -> DONE -> IDLE)
//   MAX_WIDTH   : largest supported operand width
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_t;

    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for bit_serial_adder_ctrl.
//   Operand side : in_valid, in_ready, a, b, ci, sub
//   Result side  : out_valid, out_ready, sum, co, ovf
//   Status       : busy
//   master : producer/consumer view (testbench or surrounding logic)
//   slave  : the controller's view
interface bit_serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf, busy
    );
endinterface

// File: rtl/bit_serial_adder_ctrl_serial_fa_cell.sv
// Purely combinational 1-bit full adder used once per clock by the controller.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out (majority of the three inputs)
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is stepped over WIDTH
// cycles, LSB first, with valid/ready handshakes on the operand and result sides.
//   clk  : system clock, rising edge
//   rstN : asynchronous active-low reset
//   bus  : operand/result handshake bundle (slave modport)
// Subtraction is a + ~b + 1, so co = 1 means "no borrow".
module bit_serial_adder_ctrl
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    bit_serial_adder_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    bsa_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, sum_q;
    logic             carry, co_q, ovf_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_s, fa_c;
    logic             last_bit;

    serial_fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last_bit)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            a_sr  <= '0;
            b_sr  <= '0;
            sum_q <= '0;
            carry <= 1'b0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_sr  <= bus.a;
                    b_sr  <= bus.sub ? ~bus.b : bus.b;
                    carry <= bus.sub ? 1'b1 : bus.ci;
                    cnt   <= '0;
                    sum_q <= '0;
                end
                RUN: begin
                    sum_q <= {fa_s, sum_q[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_c;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here
                        co_q  <= fa_c;
                        ovf_q <= carry ^ fa_c;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
module tb_bit_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rstN;
    int   checks;
    int   failures;

    bit_serial_adder_ctrl_if #(.WIDTH(W)) bus();

    bit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one cycle from IDLE, then count clocks to out_valid.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sub, output int lat);
        bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = ~a; bus.b = ~b;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.sum, bus.co, bus.ovf} !== {3'b100, 8'h00, 2'b00}) begin
            failures++;
            $display("FAIL reset: got rdy=%b busy=%b ov=%b sum=%h co=%b ovf=%b expected rdy=1 busy=0 ov=0 sum=00 co=0 ovf=0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.sum, bus.co, bus.ovf);
        end
        rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat;
        bus.a = 8'h3C; bus.b = 8'h05; bus.ci = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL add_busy: got busy=%b rdy=%b expected busy=1 rdy=0", bus.busy, bus.in_ready);
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL add_latency: got %0d expected 8", lat);
        end
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'h41, 2'b00}) begin
            failures++;
            $display("FAIL add_3c_05: got sum=%h co=%b ovf=%b expected sum=41 co=0 ovf=0", bus.sum, bus.co, bus.ovf);
        end
        consume();
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'h00, 2'b10} || lat !== 8) begin
            failures++;
            $display("FAIL add_ff_01: got sum=%h co=%b ovf=%b lat=%0d expected sum=00 co=1 ovf=0 lat=8",
                     bus.sum, bus.co, bus.ovf, lat);
        end
        consume();
        do_op(8'hFF, 8'h00, 1'b1, 1'b0, lat);
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'h00, 2'b10} || lat !== 8) begin
            failures++;
            $display("FAIL add_ff_00_ci: got sum=%h co=%b ovf=%b lat=%0d expected sum=00 co=1 ovf=0 lat=8",
                     bus.sum, bus.co, bus.ovf, lat);
        end
        consume();
    endtask

    task automatic test_sub();
        int lat;
        do_op(8'h05, 8'h07, 1'b1, 1'b1, lat);
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'hFE, 2'b00} || lat !== 8) begin
            failures++;
            $display("FAIL sub_05_07: got sum=%h co=%b ovf=%b lat=%0d expected sum=fe co=0 ovf=0 lat=8",
                     bus.sum, bus.co, bus.ovf, lat);
        end
        consume();
        do_op(8'h07, 8'h05, 1'b0, 1'b1, lat);
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'h02, 2'b10}) begin
            failures++;
            $display("FAIL sub_07_05: got sum=%h co=%b ovf=%b expected sum=02 co=1 ovf=0", bus.sum, bus.co, bus.ovf);
        end
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'h80, 2'b01}) begin
            failures++;
            $display("FAIL ovf_add_7f_01: got sum=%h co=%b ovf=%b expected sum=80 co=0 ovf=1", bus.sum, bus.co, bus.ovf);
        end
        consume();
        do_op(8'h80, 8'h01, 1'b0, 1'b1, lat);
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'h7F, 2'b11}) begin
            failures++;
            $display("FAIL ovf_sub_80_01: got sum=%h co=%b ovf=%b expected sum=7f co=1 ovf=1", bus.sum, bus.co, bus.ovf);
        end
        consume();
    endtask

    task automatic test_hold();
        int lat;
        do_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.a = 8'hA0 + 8'(i);
            bus.b = 8'h5F - 8'(i);
            @(posedge clk); #1;
            checks++;
            if ({bus.sum, bus.co, bus.ovf, bus.out_valid, bus.in_ready, bus.busy} !== {8'h46, 2'b00, 3'b100}) begin
                failures++;
                $display("FAIL hold_cycle%0d: got sum=%h co=%b ovf=%b ov=%b rdy=%b busy=%b expected sum=46 co=0 ovf=0 ov=1 rdy=0 busy=0",
                         i, bus.sum, bus.co, bus.ovf, bus.out_valid, bus.in_ready, bus.busy);
            end
        end
        bus.in_valid = 1'b0;
        consume();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.sum} !== {2'b01, 8'h46}) begin
            failures++;
            $display("FAIL hold_release: got ov=%b rdy=%b sum=%h expected ov=0 rdy=1 sum=46",
                     bus.out_valid, bus.in_ready, bus.sum);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(8'h20, 8'h22, 1'b0, 1'b0, lat);
        // consume and offer new operands in the same DONE cycle
        bus.a = 8'h01; bus.b = 8'h01; bus.ci = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.sum} !== {3'b100, 8'h42}) begin
            failures++;
            $display("FAIL b2b_no_early_accept: got rdy=%b busy=%b ov=%b sum=%h expected rdy=1 busy=0 ov=0 sum=42",
                     bus.in_ready, bus.busy, bus.out_valid, bus.sum);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.sum} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b sum=%h expected busy=1 sum=00", bus.busy, bus.sum);
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'h02, 2'b00} || lat !== 8) begin
            failures++;
            $display("FAIL b2b_result: got sum=%h co=%b ovf=%b lat=%0d expected sum=02 co=0 ovf=0 lat=8",
                     bus.sum, bus.co, bus.ovf, lat);
        end
        consume();
    endtask

    task automatic test_reset_midrun();
        int lat;
        bus.a = 8'h55; bus.b = 8'h11; bus.ci = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.sum} !== {1'b1, 8'hC0}) begin
            failures++;
            $display("FAIL midrun_partial: got busy=%b sum=%h expected busy=1 sum=c0", bus.busy, bus.sum);
        end
        rstN = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.sum, bus.co, bus.ovf} !== {3'b100, 8'h00, 2'b00}) begin
            failures++;
            $display("FAIL midrun_reset: got rdy=%b busy=%b ov=%b sum=%h co=%b ovf=%b expected rdy=1 busy=0 ov=0 sum=00 co=0 ovf=0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.sum, bus.co, bus.ovf);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        do_op(8'h10, 8'h20, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.sum, bus.co, bus.ovf} !== {8'h30, 2'b00} || lat !== 8) begin
            failures++;
            $display("FAIL after_reset_10_20: got sum=%h co=%b ovf=%b lat=%0d expected sum=30 co=0 ovf=0 lat=8",
                     bus.sum, bus.co, bus.ovf, lat);
        end
        consume();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_hold();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
